counter_led: RTL and testbench

Free-running 8-bit LED counter with a push-button-selectable step rate. A debounced push button cycles the step period through 1 s, 0.5 s and 0.25 s; on every period tick the value shown on `led_out` increments by one. It is a top-level board demo block, driven directly by the board clock, reset and one button, and it drives eight LEDs.

---
 rtl/counter_led.sv | 124 ++++++++++++
 tb/tb_counter_led.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_led.sv
// Free-running 8-bit LED counter whose step period (1 s / 0.5 s / 0.25 s)
// is selected by cycling a debounced push button.
module counter_led #(
    parameter int CLK_FREQ_HZ     = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_button,
    output logic [7:0] led_out
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [31:0] RELOAD_1S      = 32'(CLK_FREQ_HZ - 1);
    localparam logic [31:0] RELOAD_HALF    = 32'(CLK_FREQ_HZ / 2 - 1);
    localparam logic [31:0] RELOAD_QUARTER = 32'(CLK_FREQ_HZ / 4 - 1);

    typedef enum logic [1:0] {
        MODE_1S      = 2'd0,
        MODE_HALF    = 2'd1,
        MODE_QUARTER = 2'd2,
        MODE_BAD     = 2'd3
    } mode_t;

    logic            btn_sync_p0;
    logic            btn_sync_p1;
    logic            btn_sync;
    logic            btn_db;
    logic [DB_W-1:0] db_cnt;
    logic            btn_differs;
    logic            db_accept;
    logic            press;
    mode_t           mode;
    mode_t           mode_nxt;
    logic [31:0]     reload;
    logic [31:0]     pre_cnt;
    logic            tick;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
        end else begin
            btn_sync_p0 <= push_button;
            btn_sync_p1 <= btn_sync_p0;
        end
    end

    assign btn_sync = btn_sync_p1;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    assign btn_differs = (btn_sync != btn_db);
    assign db_accept   = btn_differs && (db_cnt == DB_LAST);
    assign press       = db_accept && btn_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (!btn_differs) begin
            db_cnt <= '0;
        end else if (db_accept) begin
            btn_db <= btn_sync;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= MODE_1S;
        end else begin
            mode <= mode_nxt;
        end
    end

    // Unreachable encoding 3 falls back to the 1 s mode on the next edge
    always_comb begin
        mode_nxt = mode;
        reload   = RELOAD_1S;
        case (mode)
            MODE_1S: begin
                reload = RELOAD_1S;
                if (press) mode_nxt = MODE_HALF;
            end
            MODE_HALF: begin
                reload = RELOAD_HALF;
                if (press) mode_nxt = MODE_QUARTER;
            end
            MODE_QUARTER: begin
                reload = RELOAD_QUARTER;
                if (press) mode_nxt = MODE_1S;
            end
            default: begin
                reload   = RELOAD_1S;
                mode_nxt = MODE_1S;
            end
        endcase
    end

    assign tick = (pre_cnt == reload);

    // A press restarts the period; a coincident tick still advances the LEDs
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            led_out <= '0;
        end else begin
            if (press || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 32'd1;
            end
            if (tick) begin
                led_out <= led_out + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_counter_led.sv
// Self-checking bench for counter_led: time-based reference model plus
// hand-computed checkpoints for reset, mode cycling, glitches, wrap and resets.
module tb_counter_led;

    localparam int CLK_FREQ = 1000;
    localparam int DB       = 8;

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       push_button = 1'b0;
    logic [7:0] led_out;

    counter_led #(
        .CLK_FREQ_HZ    (CLK_FREQ),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_button(push_button),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: edges counted since the last reset edge
    int          edge_n     = 0;
    int          m_next_due = 0;
    int          m_led      = 0;
    int          m_mode     = 0;
    bit          m_db       = 1'b0;
    bit          p0         = 1'b0;
    bit          p1         = 1'b0;
    bit [DB-1:0] win        = '0;
    bit          chk_en     = 1'b0;
    bit          dut_wrap   = 1'b0;
    logic [7:0]  prev_led   = 8'd0;

    function automatic int period(input int mode);
        case (mode)
            0:       return CLK_FREQ;
            1:       return CLK_FREQ / 2;
            default: return CLK_FREQ / 4;
        endcase
    endfunction

    // Button is accepted once the last DB synchronized samples all disagree
    // with the accepted level; ticks fall a whole period after the last
    // tick, reset or press.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            edge_n     = 0;
            m_led      = 0;
            m_mode     = 0;
            m_db       = 1'b0;
            p0         = 1'b0;
            p1         = 1'b0;
            win        = '0;
            m_next_due = period(0);
            chk_en     = 1'b1;
        end else begin
            edge_n = edge_n + 1;
            win    = {win[DB-2:0], p1};
            p1     = p0;
            p0     = push_button;
            if (edge_n == m_next_due) begin
                m_led      = (m_led + 1) % 256;
                m_next_due = edge_n + period(m_mode);
            end
            if (m_db ? (win == '0) : (&win)) begin
                m_db = ~m_db;
                if (m_db) begin
                    m_mode     = (m_mode + 1) % 3;
                    m_next_due = edge_n + period(m_mode);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_assert = n_assert + 1;
            if (led_out !== 8'(m_led)) begin
                n_fail = n_fail + 1;
                $display("FAIL led_track edge %0d: led_out=%0d expected=%0d", edge_n, led_out, m_led);
            end
            if (prev_led == 8'd255 && led_out == 8'd0) dut_wrap = 1'b1;
            prev_led = led_out;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_assert = n_assert + 1;
        if (got != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic hold_press(input int cycles);
        push_button = 1'b1;
        repeat (cycles) @(negedge clk);
        push_button = 1'b0;
    endtask

    int due;
    int base;
    int guard;

    initial begin
        // Reset held for 5 edges while the button toggles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_led", int'(led_out), 0);
            push_button = ~push_button;
        end
        rst         = 1'b0;
        push_button = 1'b0;

        wait_until(999);  check("tick1_before", int'(led_out), 0);
        wait_until(1000); check("tick1_at",     int'(led_out), 1);
        wait_until(1999); check("tick2_before", int'(led_out), 1);
        wait_until(2000); check("tick2_at",     int'(led_out), 2);

        // First press accepted at edge 2109 -> 500-cycle period
        wait_until(2099); hold_press(10);
        wait_until(2608); check("mode1_before", int'(led_out), 2);
        wait_until(2609); check("mode1_first",  int'(led_out), 3);
        wait_until(3108); check("mode1_gap",    int'(led_out), 3);
        wait_until(3109); check("mode1_second", int'(led_out), 4);

        // Second press accepted at 3209 -> 250-cycle period
        wait_until(3199); hold_press(10);
        wait_until(3458); check("mode2_before", int'(led_out), 4);
        wait_until(3459); check("mode2_first",  int'(led_out), 5);

        // Third press accepted at 3609 -> back to 1000 cycles
        wait_until(3599); hold_press(10);
        wait_until(4608); check("mode0_before", int'(led_out), 5);
        wait_until(4609); check("mode0_first",  int'(led_out), 6);

        // 5-cycle glitch must be ignored
        wait_until(4699); hold_press(5);
        wait_until(5608); check("glitch_before", int'(led_out), 6);
        wait_until(5609); check("glitch_tick",   int'(led_out), 7);

        // Long hold gives exactly one advance (mode 1, accepted at 5709)
        wait_until(5699); hold_press(200);
        wait_until(6208); check("hold_before", int'(led_out), 7);
        wait_until(6209); check("hold_first",  int'(led_out), 8);
        wait_until(6459); check("hold_single", int'(led_out), 8);
        wait_until(6709); check("hold_second", int'(led_out), 9);

        // Press accepted on the same edge as a tick
        due  = m_next_due;
        base = m_led;
        wait_until(due - 10); hold_press(10);
        check("coinc_edge", edge_n, due);
        check("coinc_inc",  int'(led_out), (base + 1) % 256);
        wait_until(due + 249); check("coinc_gap",  int'(led_out), (base + 1) % 256);
        wait_until(due + 250); check("coinc_next", int'(led_out), (base + 2) % 256);

        // Run in mode 2 until the counter wraps
        guard = 0;
        while (!dut_wrap && guard < 70000) begin
            @(negedge clk);
            guard = guard + 1;
        end
        check("wrap_255_to_0", int'(dut_wrap), 1);

        // Reset with a press mid-debounce: discarded, back to mode 0
        push_button = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_led", int'(led_out), 0);
        rst         = 1'b0;
        push_button = 1'b0;
        wait_until(999);  check("rst_mid_before", int'(led_out), 0);
        wait_until(1000); check("rst_mid_tick",   int'(led_out), 1);

        // Randomized presses, bounces and occasional resets
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(20, 120)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end else begin
                for (int c = 0; c < int'($urandom_range(1, 30)); c++) begin
                    push_button = ($urandom_range(0, 5) != 0);
                    @(negedge clk);
                end
                push_button = 1'b0;
            end
        end
        repeat (300) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
